kbd_fifo: RTL

- Downstream consumer of the PS/2 keyboard receiver in the MIO CPLD.
- Captures each completed scancode byte and checks odd parity.
- Folds the E0 (extended) and F0 (break) prefix bytes into per-entry flags and buffers the results in a small FIFO.
- Presents the FIFO, flags, status and control to the Z180 bus; raises an interrupt while data is pending.

---
 rtl/kbd_fifo.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_fifo.sv
// PS/2 scancode capture for the Z180 bus: odd-parity check, E0/F0 prefix folding into
// per-entry flags, a 2^DEPTH_LOG2-entry FIFO, status/control registers and a level interrupt.
module kbd_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_parity,
    input  logic       rx_done,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       kb_int
);

    localparam int DEPTH = 32'sd1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 32'sd1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ZERO = CW'(1'b0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

    // A byte is good when data plus parity bit hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
    logic                  ovf_q, ovf_d, perr_q, perr_d, int_en_q, int_en_d;
    logic                  kb_int_q;
    logic                  rxd_meta_q, rxd_sync_q, rxd_dly_q;
    logic [1:0]            prime_q;
    logic                  rd_q, wr_q;

    logic       push_ev_s, rd_edge_s, wr_edge_s, empty_s, full_s;
    logic       pop_s, stat_clr_s, cfg_wr_s, flush_s;
    logic       par_err_s, ext_ev_s, brk_ev_s, data_ev_s, store_s, ovf_ev_s;
    logic [9:0] head_ent_s;
    logic [3:0] count4_s;
    logic       unused_data_s;

    assign unused_data_s = ^data_in[7:2];

    // rx_done synchroniser, edge-detect stage and bus strobe history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q <= 1'b0;
            rxd_sync_q <= 1'b0;
            rxd_dly_q  <= 1'b0;
            prime_q    <= 2'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            rxd_meta_q <= rx_done;
            rxd_sync_q <= rxd_meta_q;
            rxd_dly_q  <= rxd_sync_q;
            prime_q    <= (prime_q == 2'd3) ? 2'd3 : (prime_q + 2'd1);
            rd_q       <= rd;
            wr_q       <= wr;
        end
    end

    // Event decode. The edge detector arms only once every stage of the chain holds a real
    // sample, so a level already high when reset releases is not taken for a new byte.
    always_comb begin
        push_ev_s  = rxd_sync_q & ~rxd_dly_q & (prime_q == 2'd3);
        rd_edge_s  = rd & ~rd_q;
        wr_edge_s  = wr & ~wr_q;
        empty_s    = (count_q == CNT_ZERO);
        full_s     = (count_q == FULL_CNT);
        pop_s      = rd_edge_s & (addr == 2'd0) & ~empty_s;
        stat_clr_s = rd_edge_s & (addr == 2'd2);
        cfg_wr_s   = wr_edge_s & (addr == 2'd3);
        flush_s    = cfg_wr_s & data_in[0];
    end

    // Classify the received byte: parity error, extended prefix, break prefix or data.
    always_comb begin
        par_err_s = 1'b0;
        ext_ev_s  = 1'b0;
        brk_ev_s  = 1'b0;
        data_ev_s = 1'b0;
        if (push_ev_s) begin
            if (!parity_ok(rx_data, rx_parity)) begin
                par_err_s = 1'b1;
            end else if (rx_data == 8'hE0) begin
                ext_ev_s = 1'b1;
            end else if (rx_data == 8'hF0) begin
                brk_ev_s = 1'b1;
            end else begin
                data_ev_s = 1'b1;
            end
        end else begin
            data_ev_s = 1'b0;
        end
        // A pop in the same cycle frees the slot the push needs.
        store_s  = data_ev_s & (~full_s | pop_s) & ~flush_s;
        ovf_ev_s = data_ev_s & full_s & ~pop_s;
    end

    // Next-state for pointers, count, prefix flags, sticky errors and interrupt enable.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        int_en_d   = int_en_q;
        if (flush_s) begin
            head_d     = DEPTH_LOG2'(1'b0);
            tail_d     = DEPTH_LOG2'(1'b0);
            count_d    = CNT_ZERO;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
            ovf_d      = 1'b0;
            perr_d     = 1'b0;
            int_en_d   = data_in[1];
        end else begin
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (store_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CW'(store_s) - CW'(pop_s);
            if (par_err_s || data_ev_s) begin
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
            end else if (ext_ev_s) begin
                pend_ext_d = 1'b1;
            end else if (brk_ev_s) begin
                pend_brk_d = 1'b1;
            end else begin
                pend_ext_d = pend_ext_q;
            end
            // A new error outranks the clear-on-read of the status register.
            if (ovf_ev_s) begin
                ovf_d = 1'b1;
            end else if (stat_clr_s) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
            if (par_err_s) begin
                perr_d = 1'b1;
            end else if (stat_clr_s) begin
                perr_d = 1'b0;
            end else begin
                perr_d = perr_q;
            end
            if (cfg_wr_s) begin
                int_en_d = data_in[1];
            end else begin
                int_en_d = int_en_q;
            end
        end
    end

    // FIFO control and status state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= DEPTH_LOG2'(1'b0);
            tail_q     <= DEPTH_LOG2'(1'b0);
            count_q    <= CNT_ZERO;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            int_en_q   <= 1'b0;
            kb_int_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            int_en_q   <= int_en_d;
            kb_int_q   <= int_en_q & ~empty_s;
        end
    end

    // FIFO storage: {brk, ext, code}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 32'sd0; i < DEPTH; i = i + 32'sd1) begin
                mem_q[i] <= 10'h000;
            end
        end else if (store_s) begin
            mem_q[tail_q] <= {pend_brk_q, pend_ext_q, rx_data};
        end else begin
            mem_q[tail_q] <= mem_q[tail_q];
        end
    end

    // Bus read mux; empty FIFO reads as zero.
    always_comb begin
        head_ent_s = mem_q[head_q];
        count4_s   = 4'(count_q);
        data_out   = 8'h00;
        case (addr)
            2'd0: begin
                if (empty_s) begin
                    data_out = 8'h00;
                end else begin
                    data_out = head_ent_s[7:0];
                end
            end
            2'd1: begin
                if (empty_s) begin
                    data_out = 8'h00;
                end else begin
                    data_out = {6'b000000, head_ent_s[9:8]};
                end
            end
            2'd2:    data_out = {ovf_q, perr_q, pend_ext_q, pend_brk_q, count4_s};
            2'd3:    data_out = {6'b000000, int_en_q, 1'b0};
            default: data_out = 8'h00;
        endcase
    end

    assign kb_int = kb_int_q;

endmodule
